// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch port and the data port.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking (default is fixed DM priority).
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_valid_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_valid_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   // state   | meaning
   // IDLE    | no access outstanding, arbitrate eligible requests
   // BUSY_IF | fetch access outstanding on the memory bus
   // BUSY_DM | load/store access outstanding on the memory bus
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

   localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam bit             WD_EN    = (TIMEOUT != 0);
   localparam logic [31:0]    NOP      = 32'h0000_0013;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic          if_valid_q, if_valid_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;
   logic          dm_valid_q, dm_valid_d;
   logic          err_q, err_d;

   logic if_elig, dm_elig;
   logic grant_if, grant_dm;
   logic timeout_hit;

   // A port whose valid is pulsing this cycle has just been served.
   assign if_elig = if_req_i & ~if_valid_q;
   assign dm_elig = dm_req_i & ~dm_valid_q;

`ifdef MEM_ARB_RR_EN
   logic last_grant_q;  // 0 = IF, 1 = DM

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         last_grant_q <= 1'b0;
      end else if ((state_q == IDLE) && (if_elig || dm_elig)) begin
         last_grant_q <= grant_dm;
      end
   end

   assign grant_dm = dm_elig & (~if_elig | ~last_grant_q);
`else
   assign grant_dm = dm_elig;
`endif
   assign grant_if = if_elig & ~grant_dm;

   // cnt_q+1 is the number of BUSY cycles including the current one.
   assign timeout_hit = WD_EN && (cnt_q == CNT_LAST);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_rdata_q  <= '0;
         dm_valid_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_valid_q  <= dm_valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_dm) begin
               state_d = BUSY_DM;
            end else if (grant_if) begin
               state_d = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_ack_i || timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      if_valid_d  = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      dm_valid_d  = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_dm) begin
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
            end else if (grant_if) begin
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr_i;
            end
         end
         BUSY_IF: begin
            if (mem_ack_i) begin
               if_rdata_d = mem_rdata_i;
               if_valid_d = 1'b1;
               mem_req_d  = 1'b0;
            end else if (timeout_hit) begin
               if_rdata_d = NOP;
               if_valid_d = 1'b1;
               err_d      = 1'b1;
               mem_req_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BUSY_DM: begin
            if (mem_ack_i) begin
               if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata_i;
               end
               dm_valid_d = 1'b1;
               mem_req_d  = 1'b0;
            end else if (timeout_hit) begin
               dm_rdata_d = '0;
               dm_valid_d = 1'b1;
               err_d      = 1'b1;
               mem_req_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Built from inputs and valid registers only, so no path from mem_ack_i.
   assign stall_o = (if_req_i & ~if_valid_q) | (dm_req_i & ~dm_valid_q);

   assign if_rdata_o  = if_rdata_q;
   assign if_valid_o  = if_valid_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign dm_valid_o  = dm_valid_q;
   assign err_o       = err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable memory responder.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic [31:0] if_rdata_o;
   logic        if_valid_o;
   logic        dm_req_i = 1'b0;
   logic        dm_we_i = 1'b0;
   logic [31:0] dm_addr_i = '0;
   logic [31:0] dm_wdata_i = '0;
   logic [31:0] dm_rdata_o;
   logic        dm_valid_o;
   logic        stall_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   int          ack_lat  = -1;
   logic [31:0] mem_data = '0;
   int          busy_cnt = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.TIMEOUT(4)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_rdata_o (if_rdata_o),
      .if_valid_o (if_valid_o),
      .dm_req_i   (dm_req_i),
      .dm_we_i    (dm_we_i),
      .dm_addr_i  (dm_addr_i),
      .dm_wdata_i (dm_wdata_i),
      .dm_rdata_o (dm_rdata_o),
      .dm_valid_o (dm_valid_o),
      .stall_o    (stall_o),
      .err_o      (err_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i),
      .mem_ack_i  (mem_ack_i)
   );

   // Acks on the (ack_lat+1)-th cycle of mem_req; ack_lat < 0 never acks.
   always @(negedge clk_i) begin
      if (mem_req_o) begin
         mem_ack_i   = (busy_cnt == ack_lat);
         mem_rdata_i = mem_data;
         busy_cnt++;
      end else begin
         mem_ack_i   = 1'b0;
         mem_rdata_i = '0;
         busy_cnt    = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic wait_pulse(input bit dm, input int max, output int cyc, output int mreq);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      mreq = 0;
      while (!seen && cyc < max) begin
         @(negedge clk_i);
         cyc++;
         if (mem_req_o) mreq++;
         seen = dm ? dm_valid_o : if_valid_o;
         if (!seen) check("stall_busy", stall_o, 1);
      end
   endtask

   // Issues one access at a negedge; lat counts cycles from request to valid pulse.
   task automatic access(input string tag, input bit dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int mreq);
      int cyc, mr;
      if (dm) begin
         dm_req_i   = 1'b1;
         dm_we_i    = we;
         dm_addr_i  = addr;
         dm_wdata_i = wdata;
      end else begin
         if_req_i  = 1'b1;
         if_addr_i = addr;
      end
      #1 check({tag, "_stall_req"}, stall_o, 1);
      @(negedge clk_i);
      check({tag, "_mreq"}, mem_req_o, 1);
      check({tag, "_mwe"}, mem_we_o, 32'(dm & we));
      check({tag, "_maddr"}, mem_addr_o, addr);
      if (dm && we) check({tag, "_mwdata"}, mem_wdata_o, wdata);
      wait_pulse(dm, 20, cyc, mr);
      lat  = cyc + 1;
      mreq = mr + 1;
      check({tag, "_stall_done"}, stall_o, 0);
      dm_req_i = 1'b0;
      if_req_i = 1'b0;
      dm_we_i  = 1'b0;
   endtask

   task automatic tie(output int dm_at, output int if_at, output logic [31:0] a1,
                      output logic [31:0] a3);
      ack_lat   = 0;
      if_req_i  = 1'b1;
      if_addr_i = 32'h14;
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h80;
      dm_at = 0;
      if_at = 0;
      a1 = '0;
      a3 = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk_i);
         if (c == 1) a1 = mem_addr_o;
         if (c == 3) a3 = mem_addr_o;
         if (dm_valid_o && dm_at == 0) begin
            dm_at    = c;
            dm_req_i = 1'b0;
         end
         if (if_valid_o && if_at == 0) begin
            if_at    = c;
            if_req_i = 1'b0;
         end
      end
      dm_req_i = 1'b0;
      if_req_i = 1'b0;
   endtask

   initial begin
      int lat, mr, dm_at, if_at;
      logic [31:0] a1, a3;

      repeat (2) @(negedge clk_i);
      check("rst_mem_req", mem_req_o, 0);
      check("rst_if_valid", if_valid_o, 0);
      check("rst_dm_valid", dm_valid_o, 0);
      check("rst_err", err_o, 0);
      check("rst_if_rdata", if_rdata_o, 0);
      check("rst_dm_rdata", dm_rdata_o, 0);
      check("rst_stall", stall_o, 0);
      reset_i = 1'b0;
      @(negedge clk_i);

      // fetch, ack on the third mem_req cycle
      ack_lat  = 2;
      mem_data = 32'h0050_0093;
      access("t1", 0, 0, 32'h10, 32'h0, lat, mr);
      check("t1_lat", lat, 4);
      check("t1_mreq_cycles", mr, 3);
      check("t1_if_rdata", if_rdata_o, 32'h0050_0093);
      check("t1_err", err_o, 0);
      @(negedge clk_i);
      check("t1_if_valid_pulse", if_valid_o, 0);

      // zero-wait load, then a store that must leave dm_rdata alone
      ack_lat  = 0;
      mem_data = 32'h1234_5678;
      access("t2_ld", 1, 0, 32'h44, 32'h0, lat, mr);
      check("t2_ld_lat", lat, 2);
      check("t2_ld_rdata", dm_rdata_o, 32'h1234_5678);
      @(negedge clk_i);
      ack_lat  = 1;
      mem_data = 32'hDEAD_BEEF;
      access("t2_st", 1, 1, 32'h40, 32'hCAFE_F00D, lat, mr);
      check("t2_st_lat", lat, 3);
      check("t2_st_rdata_hold", dm_rdata_o, 32'h1234_5678);
      check("t2_st_err", err_o, 0);
      @(negedge clk_i);
      check("t2_dm_valid_pulse", dm_valid_o, 0);

      // ties from reset: DM first in both builds
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      tie(dm_at, if_at, a1, a3);
      check("t3a_dm_at", dm_at, 2);
      check("t3a_if_at", if_at, 4);
      check("t3a_addr1", a1, 32'h80);
      check("t3a_addr3", a3, 32'h14);
      ack_lat = 0;
      access("t3_ld", 1, 0, 32'h84, 32'h0, lat, mr);
      @(negedge clk_i);
      tie(dm_at, if_at, a1, a3);
`ifdef MEM_ARB_RR_EN
      check("t3b_dm_at", dm_at, 4);
      check("t3b_if_at", if_at, 2);
      check("t3b_addr1", a1, 32'h14);
      check("t3b_addr3", a3, 32'h80);
`else
      check("t3b_dm_at", dm_at, 2);
      check("t3b_if_at", if_at, 4);
      check("t3b_addr1", a1, 32'h80);
      check("t3b_addr3", a3, 32'h14);
`endif

      // ack on the last allowed BUSY cycle wins over the timeout
      ack_lat  = 3;
      mem_data = 32'hA5A5_5A5A;
      access("t5", 1, 0, 32'h48, 32'h0, lat, mr);
      check("t5_lat", lat, 5);
      check("t5_mreq_cycles", mr, 4);
      check("t5_err", err_o, 0);
      check("t5_dm_rdata", dm_rdata_o, 32'hA5A5_5A5A);
      @(negedge clk_i);

      // fetch timeout returns a NOP
      ack_lat = -1;
      access("t4_if", 0, 0, 32'h20, 32'h0, lat, mr);
      check("t4_if_lat", lat, 5);
      check("t4_if_mreq_cycles", mr, 4);
      check("t4_if_err", err_o, 1);
      check("t4_if_rdata", if_rdata_o, 32'h0000_0013);
      @(negedge clk_i);
      check("t4_if_err_pulse", err_o, 0);
      check("t4_if_valid_pulse", if_valid_o, 0);

      // data timeout returns zero
      access("t4_dm", 1, 0, 32'h50, 32'h0, lat, mr);
      check("t4_dm_lat", lat, 5);
      check("t4_dm_err", err_o, 1);
      check("t4_dm_rdata", dm_rdata_o, 32'h0);
      @(negedge clk_i);

      // reset while BUSY_DM
      ack_lat   = -1;
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h60;
      @(negedge clk_i);
      check("t6_mreq_busy", mem_req_o, 1);
      @(negedge clk_i);
      reset_i  = 1'b1;
      dm_req_i = 1'b0;
      #1;
      check("t6_mreq_rst", mem_req_o, 0);
      check("t6_dm_valid_rst", dm_valid_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         check("t6_no_valid", dm_valid_o, 0);
         check("t6_no_err", err_o, 0);
         check("t6_mreq_idle", mem_req_o, 0);
      end
      ack_lat  = 0;
      mem_data = 32'h1111_2222;
      access("t6_after", 0, 0, 32'h30, 32'h0, lat, mr);
      check("t6_after_lat", lat, 2);
      check("t6_after_rdata", if_rdata_o, 32'h1111_2222);
      @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
